systolic_data_feeder: RTL and testbench
=======================================

Name: systolic_data_feeder

Overview:
Upstream stage of systolic_data_setup_unit. Accepts a read descriptor (base address, row count) and streams rows from the unified buffer, which has a fixed 1-cycle read latency. Each row is presented as MATRIX_WIDTH bytes with an enable strobe, followed by MATRIX_WIDTH-1 zero flush rows so the skewed tail drains through the setup unit. Supports downstream back-pressure through a skid register.

Parameters:
MATRIX_WIDTH, 14, bytes per row; must match systolic_data_setup_unit.
ADDR_WIDTH, 24, unified buffer address width.
COUNT_WIDTH, 16, width of row_count.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  descriptor strobe; accepted only in IDLE.
base_addr  in  ADDR_WIDTH  first buffer address.
row_count  in  COUNT_WIDTH  number of rows to fetch.
busy  out  1  high from the accept edge until done.
done  out  1  one-cycle pulse at job end.
hold  in  1  downstream stall.
buf_rd_en  out  1  buffer read strobe.
buf_rd_addr  out  ADDR_WIDTH  buffer read address.
buf_rd_data  in  MATRIX_WIDTH x byte_type  read data, valid 1 cycle after buf_rd_en.
data_out  out  MATRIX_WIDTH x byte_type  row to systolic_data_setup_unit data_in.
data_enable  out  1  to systolic_data_setup_unit enable; row consumed when high.

Behaviour:
- Reset, or rst asserted mid-job: FSM returns to IDLE. busy, done, buf_rd_en and data_enable are 0. buf_rd_addr and data_out are 0. Skid and counters are cleared. Any in-flight read data is discarded.
- FSM states: IDLE, FETCH, DRAIN, FLUSH, DONE.
- IDLE:
  - On start=1, latch base_addr and row_count, and set busy=1 after the edge.
  - row_count!=0 -> FETCH.
  - row_count=0 -> DONE. No reads issued and data_enable never asserted.
- FETCH:
  - Issue buf_rd_en=1 with buf_rd_addr = base + i, for i = 0..N-1, one per cycle.
  - An issue happens only when the output register will be free. With hold=0, issues are back-to-back.
  - Address increments modulo 2^ADDR_WIDTH; wrap-around is legal.
  - After the last issue -> DRAIN.
- Output register:
  - Loaded from buf_rd_data on the edge after the read sample, or from the skid register if occupied.
  - data_enable = out_valid & ~hold, combinational gating of a registered valid.
  - Latency: start accepted at edge E0 -> buf_rd_en high in cycle after E0 -> first data_enable high after E2.
  - Unstalled rows are contiguous: N consecutive cycles of data_enable=1.
- hold=1:
  - data_out frozen, data_enable=0, no new read issued.
  - A read already in flight lands in the one-entry skid register.
  - On hold release: output register row is consumed first, then the skid row, then issue resumes.
  - No row is lost or duplicated.
- DRAIN: wait until all N rows have been consumed -> FLUSH.
- FLUSH:
  - Present MATRIX_WIDTH-1 rows of all-zero data_out, each with data_enable=1.
  - Honours hold the same way as data rows.
  - Then -> DONE.
- DONE: done=1 for one cycle, busy=0 on the following edge -> IDLE.
- start while busy: ignored, descriptor not latched.
- start in the same cycle as done: ignored. It is accepted the next cycle in IDLE.
- row_count=1: one read, one data row, then MATRIX_WIDTH-1 flush rows.

Optional Feature:
Macro: TPU_FEEDER_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [31:0].
  - Counts cycles with busy=1 and hold=1.
  - Cleared on reset and on each accepted start; saturates at 2^32-1.
  - Value stays stable after done until the next start.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles mid-FETCH of a 5-row job -> all outputs 0 immediately. After release, no data_enable until a new start.
- Basic job: MATRIX_WIDTH=10, base_addr=0x10, row_count=5, hold=0, buffer model row k = {10k+1..10k+10} -> buf_rd_addr 0x10..0x14 consecutive. data_enable high 2 cycles after accept for 5 cycles with rows 1-10 .. 41-50, then 9 zero rows, then done pulse.
- Stall: same job, hold=1 for 3 cycles starting the cycle row 1 is presented -> data_out frozen at row 1, data_enable=0, at most one read outstanding. After release, rows 1,2,3,4 follow in order, no duplicates. Total enabled cycles = 14. stall_cycles=3 when macro defined.
- Zero/one rows: row_count=0 -> no buf_rd_en, done 1 cycle after DONE entry. row_count=1 -> exactly one read and 1+9 enabled cycles.
- Address wrap: ADDR_WIDTH=4, base_addr=0xE, row_count=4 -> addresses 0xE, 0xF, 0x0, 0x1.
- start while busy: second start with different base mid-job -> ignored; original sequence completes unchanged.

Source files
------------

// File: rtl/systolic_data_feeder.sv
// Streams descriptor-addressed rows from the unified buffer (1-cycle read latency) to the
// systolic setup unit, then MATRIX_WIDTH-1 zero flush rows. `TPU_FEEDER_STALL_CNT_EN adds stall_cycles.
module systolic_data_feeder #(
  parameter int MATRIX_WIDTH = 14,
  parameter int ADDR_WIDTH   = 24,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [COUNT_WIDTH-1:0]        row_count,
  output logic                          busy,
  output logic                          done,
  input  logic                          hold,
  output logic                          buf_rd_en,
  output logic [ADDR_WIDTH-1:0]         buf_rd_addr,
  input  logic [MATRIX_WIDTH-1:0][7:0]  buf_rd_data,
  output logic [MATRIX_WIDTH-1:0][7:0]  data_out,
`ifdef TPU_FEEDER_STALL_CNT_EN
  output logic [31:0]                   stall_cycles,
`endif
  output logic                          data_enable
);
  localparam int FW = (MATRIX_WIDTH > 2) ? $clog2(MATRIX_WIDTH) : 1;
  localparam int TW = COUNT_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_FLUSH, S_DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]        addr;
  logic [COUNT_WIDTH-1:0]       cnt, issued;
  logic [TW-1:0]                cons, total;
  logic [FW-1:0]                flush_ld;
  logic                         rd_pend, skid_valid, out_valid;
  logic [MATRIX_WIDTH-1:0][7:0] skid_data, out_data;
  logic                         accept, issue, consume, out_free, flush_ready;

  assign accept   = (state == S_IDLE) && start;
  // No issue while the skid is occupied: guarantees an in-flight row always has a landing slot.
  assign issue    = (state == S_FETCH) && !hold && !skid_valid;
  assign consume  = out_valid && !hold;
  assign out_free = !out_valid || consume;
  assign flush_ready = ((state == S_DRAIN) || (state == S_FLUSH)) && !rd_pend && !skid_valid &&
                       (flush_ld != FW'(MATRIX_WIDTH - 1));
  assign total    = TW'(cnt) + TW'(MATRIX_WIDTH - 1);

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign buf_rd_en   = issue;
  assign buf_rd_addr = addr;
  assign data_out    = out_data;
  assign data_enable = consume;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (row_count == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (issue && (issued == cnt - COUNT_WIDTH'(1))) state_nxt = S_DRAIN;
      S_DRAIN: if (cons >= TW'(cnt)) state_nxt = S_FLUSH;
      S_FLUSH: if (cons == total) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      cnt        <= '0;
      issued     <= '0;
      cons       <= '0;
      flush_ld   <= '0;
      rd_pend    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      rd_pend <= issue;
      if (issue) begin
        addr   <= addr + ADDR_WIDTH'(1);
        issued <= issued + COUNT_WIDTH'(1);
      end
      if (consume) cons <= cons + TW'(1);
      // Output register priority: held row stays, then skid, then fresh read, then flush zeros.
      if (!out_free) begin
        if (rd_pend) begin
          skid_data  <= buf_rd_data;
          skid_valid <= 1'b1;
        end
      end else if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (rd_pend) begin
        out_data  <= buf_rd_data;
        out_valid <= 1'b1;
      end else if (flush_ready) begin
        out_data  <= '0;
        out_valid <= 1'b1;
        flush_ld  <= flush_ld + FW'(1);
      end else begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        addr     <= base_addr;
        cnt      <= row_count;
        issued   <= '0;
        cons     <= '0;
        flush_ld <= '0;
      end
    end
  end

`ifdef TPU_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                stall_cycles <= '0;
    else if (accept)                        stall_cycles <= '0;
    else if (busy && hold && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_systolic_data_feeder.sv
// Randomized bench: expected read addresses and enabled rows come from a queue model of the job.
module tb_systolic_data_feeder;
  localparam int M  = 10;
  localparam int AW = 6;
  localparam int CW = 8;

  logic clk = 0, rst = 1, start = 0, hold = 0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] row_count = '0;
  logic busy, done, buf_rd_en, data_enable;
  logic [AW-1:0] buf_rd_addr;
  logic [M-1:0][7:0] buf_rd_data = '0, data_out;
`ifdef TPU_FEEDER_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  systolic_data_feeder #(.MATRIX_WIDTH(M), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_count(row_count),
    .busy(busy), .done(done), .hold(hold), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data), .data_out(data_out),
`ifdef TPU_FEEDER_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .data_enable(data_enable));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  logic [M-1:0][7:0] mem [64];
  always @(posedge clk) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0]     exp_addr[$];
  logic [M-1:0][7:0] exp_row[$];
  bit mon_en = 0;
  int en_cnt, done_cnt, first_en, last_en, stall_model;

  always @(negedge clk) if (mon_en) begin
    if (buf_rd_en) begin
      if (exp_addr.size() == 0) check("rd_extra", 1, 0);
      else check("rd_addr", buf_rd_addr, exp_addr.pop_front());
    end
    if (hold) check("en_hold", data_enable, 0);
    if (data_enable) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      if (exp_row.size() == 0) check("row_extra", 1, 0);
      else check("row", data_out, exp_row.pop_front());
    end
    if (done) done_cnt++;
    if (busy && hold) stall_model++;
  end

  // mode 0: no hold, 1: random hold, 2: hold for the 3 cycles the first row is presented
  task automatic run_job(input logic [AW-1:0] base, input int n, input int mode, input bit poke);
    int c;
    int acc;
    logic [AW-1:0] a;
    exp_addr.delete();
    exp_row.delete();
    for (int i = 0; i < n; i++) begin
      a = AW'((int'(base) + i) % 64);
      exp_addr.push_back(a);
      exp_row.push_back(mem[a]);
    end
    if (n > 0) for (int i = 0; i < M - 1; i++) exp_row.push_back('0);
    en_cnt = 0; done_cnt = 0; first_en = -1; last_en = -1; stall_model = 0;
    base_addr = base; row_count = CW'(n); start = 1; hold = 0; mon_en = 1;
    @(posedge clk); #1;
    start = 0; acc = cyc; c = 0;
    while (done_cnt == 0 && c < 600) begin
      case (mode)
        1:       hold = ($urandom_range(0, 2) == 0);
        2:       hold = (c >= 2 && c <= 4);
        default: hold = 0;
      endcase
      if (poke && c == 3) begin
        start = 1; base_addr = base + AW'(7); row_count = CW'(n + 3);
      end else start = 0;
      @(posedge clk); #1;
      c++;
    end
    hold = 0; start = 0;
    check("done_seen", done_cnt, 1);
    check("busy_after", busy, 0);
    check("addr_left", exp_addr.size(), 0);
    check("rows_left", exp_row.size(), 0);
    check("en_cnt", en_cnt, (n > 0) ? n + M - 1 : 0);
    if (mode == 0 && n > 0) begin
      check("latency", first_en - acc, 2);
      check("contig", last_en - first_en + 1, n + M - 1);
    end
`ifdef TPU_FEEDER_STALL_CNT_EN
    check("stall_cnt", stall_cycles, stall_model);
    if (mode == 2) check("stall3", stall_cycles, 3);
`endif
    mon_en = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int a = 0; a < 64; a++)
      for (int j = 0; j < M; j++) mem[a][j] = 8'((a - 16) * 10 + j + 1);
    #1;
    check("rst_outs", {busy, done, buf_rd_en, data_enable, buf_rd_addr, data_out}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    run_job(6'h10, 5, 0, 0);
    run_job(6'h10, 5, 2, 0);
    run_job(6'h00, 0, 0, 0);
    run_job(6'h22, 1, 0, 0);
    run_job(6'h3E, 4, 0, 0);
    run_job(6'h08, 6, 0, 1);

    // Reset mid-FETCH: outputs clear immediately, nothing restarts on its own.
    base_addr = 6'h10; row_count = 5; start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1 rst = 1;
    #1 check("rst_mid", {busy, done, buf_rd_en, data_enable, buf_rd_addr, data_out}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst", {busy, data_enable, buf_rd_en}, 0);
    end
    @(posedge clk); #1;

    for (int a = 0; a < 64; a++)
      for (int j = 0; j < M; j++) mem[a][j] = 8'($urandom);
    for (int k = 0; k < 10; k++)
      run_job(AW'($urandom_range(0, 63)), $urandom_range(0, 7), 1, ($urandom_range(0, 3) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
